// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SLICE-bit lookahead slice per stage,
// with carry-in/out, signed overflow, zero flag and a valid/ready output handshake.
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTAGE = WIDTH / SLICE;

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_param
    $error("cla_pipe_addsub: WIDTH must be a non-zero multiple of SLICE");
  end

  // Returns {carry into slice MSB, carry out, sum}; every carry is a flat lookahead term.
  function automatic logic [SLICE+1:0] cla_slice(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic             ci);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             acc;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE; i++) begin
      for (int j = 0; j <= i; j++) begin
        acc = g[j];
        for (int m = j + 1; m <= i; m++) acc = acc & p[m];
        c[i+1] = c[i+1] | acc;
      end
      acc = ci;
      for (int m = 0; m <= i; m++) acc = acc & p[m];
      c[i+1] = c[i+1] | acc;
    end
    return {c[SLICE-1], c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  logic [NSTAGE:1]  v_q, v_d;
  logic [NSTAGE:1]  c_q, c_d;
  logic [NSTAGE:1]  en;
  logic [WIDTH-1:0] res_q [1:NSTAGE];
  logic [WIDTH-1:0] res_d [1:NSTAGE];
  logic [WIDTH-1:0] a_q   [1:NSTAGE];
  logic [WIDTH-1:0] a_d   [1:NSTAGE];
  logic [WIDTH-1:0] b_q   [1:NSTAGE];
  logic [WIDTH-1:0] b_d   [1:NSTAGE];
  logic [SLICE+1:0] r     [0:NSTAGE-1];
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             adv;
  logic [WIDTH-1:0] beff;

  // Handshake: a beat moves on an edge where valid && ready. The whole pipe advances
  // together when the output slot is empty or being consumed, otherwise it freezes.
  always_comb begin
    adv  = !v_q[NSTAGE] || out_ready;
    beff = sub ? ~B : B;

    r[0] = cla_slice(A[SLICE-1:0], beff[SLICE-1:0], cin ^ sub);
    for (int k = 1; k < NSTAGE; k++) begin
      r[k] = cla_slice(a_q[k][k*SLICE +: SLICE], b_q[k][k*SLICE +: SLICE], c_q[k]);
    end

    v_d[1]                  = in_valid;
    en[1]                   = adv && in_valid;
    res_d[1]                = '0;
    res_d[1][SLICE-1:0]     = r[0][SLICE-1:0];
    c_d[1]                  = r[0][SLICE];
    a_d[1]                  = A;
    a_d[1][SLICE-1:0]       = '0;
    b_d[1]                  = beff;
    b_d[1][SLICE-1:0]       = '0;

    // Slice k of each operand is cleared once consumed; only the upper slices travel on.
    for (int k = 1; k < NSTAGE; k++) begin
      v_d[k+1]                       = v_q[k];
      en[k+1]                        = adv && v_q[k];
      res_d[k+1]                     = res_q[k];
      res_d[k+1][k*SLICE +: SLICE]   = r[k][SLICE-1:0];
      c_d[k+1]                       = r[k][SLICE];
      a_d[k+1]                       = a_q[k];
      a_d[k+1][k*SLICE +: SLICE]     = '0;
      b_d[k+1]                       = b_q[k];
      b_d[k+1][k*SLICE +: SLICE]     = '0;
    end

    ovf_d  = r[NSTAGE-1][SLICE+1] ^ r[NSTAGE-1][SLICE];
    zero_d = (res_d[NSTAGE] == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 1; k <= NSTAGE; k++) begin
        res_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      if (adv) v_q <= v_d;
      for (int k = 1; k <= NSTAGE; k++) begin
        if (en[k]) begin
          res_q[k] <= res_d[k];
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          c_q[k]   <= c_d[k];
        end
      end
      if (en[NSTAGE]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[NSTAGE];
  assign S         = res_q[NSTAGE];
  assign cout      = c_q[NSTAGE];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
